// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - E-register inputs, forwarding outputs and M-register outputs of the execute stage
interface execute_stage_if;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [63:0] E_valC;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [1:0]  E_stat;
  logic        M_bubble;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc;
  logic [3:0]  M_icode;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic        M_Cnd;
  logic [1:0]  M_stat;

  // Upstream side: drives the E register contents and pipeline control
  modport master (
    output E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
    output M_bubble, m_stat, W_stat,
    input  e_valE, e_dstE, e_Cnd, cc,
    input  M_icode, M_dstE, M_dstM, M_valE, M_valA, M_Cnd, M_stat
  );

  // Execute stage side
  modport slave (
    input  E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
    input  M_bubble, m_stat, W_stat,
    output e_valE, e_dstE, e_Cnd, cc,
    output M_icode, M_dstE, M_dstM, M_valE, M_valA, M_Cnd, M_stat
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, condition codes, branch/cmove condition, M register (optional EXECUTE_CC_GATE_EN gates CC on downstream status)
module execute_stage (
  input  logic clk,
  input  logic rst_n,
  execute_stage_if.slave bus
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [1:0] SAOK    = 2'd0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_ZERO = 3'd4
  } alu_op_e;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_out;
  alu_op_e     alu_op;
  logic        new_zf;
  logic        new_sf;
  logic        new_of;
  logic        cond;
  logic        cc_we;
  logic        zf;
  logic        sf;
  logic        of_flag;

  assign zf      = bus.cc[2];
  assign sf      = bus.cc[1];
  assign of_flag = bus.cc[0];

  // Select ALU operands from the instruction class
  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    case (bus.E_icode)
      IRRMOVQ, IOPQ:             alu_a = bus.E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = bus.E_valC;
      ICALL, IPUSHQ:             alu_a = -64'sd8;
      IRET, IPOPQ:               alu_a = 64'd8;
      default:                   alu_a = 64'd0;
    endcase
    case (bus.E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = bus.E_valB;
      default:                                           alu_b = 64'd0;
    endcase
  end

  // Only OPq uses ifun as the ALU function; undefined OPq functions produce zero
  always_comb begin
    alu_op = ALU_ADD;
    if (bus.E_icode == IOPQ) begin
      case (bus.E_ifun)
        4'd0:    alu_op = ALU_ADD;
        4'd1:    alu_op = ALU_SUB;
        4'd2:    alu_op = ALU_AND;
        4'd3:    alu_op = ALU_XOR;
        default: alu_op = ALU_ZERO;
      endcase
    end
  end

  // ALU datapath and the flags it would write; subtraction is aluB - aluA
  always_comb begin
    alu_out = 64'd0;
    new_of  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_out = alu_b + alu_a;
        new_of  = (alu_a[63] == alu_b[63]) && (alu_out[63] != alu_a[63]);
      end
      ALU_SUB: begin
        alu_out = alu_b - alu_a;
        new_of  = (alu_a[63] != alu_b[63]) && (alu_out[63] != alu_b[63]);
      end
      ALU_AND: alu_out = alu_b & alu_a;
      ALU_XOR: alu_out = alu_b ^ alu_a;
      default: alu_out = 64'd0;
    endcase
    new_zf = (alu_out == 64'd0);
    new_sf = alu_out[63];
  end

  // Branch / conditional-move condition from the currently held flags
  always_comb begin
    cond = 1'b1;
    if (bus.E_icode == IRRMOVQ || bus.E_icode == IJXX) begin
      case (bus.E_ifun)
        4'd0:    cond = 1'b1;
        4'd1:    cond = (sf ^ of_flag) | zf;
        4'd2:    cond = sf ^ of_flag;
        4'd3:    cond = zf;
        4'd4:    cond = !zf;
        4'd5:    cond = !(sf ^ of_flag);
        4'd6:    cond = !(sf ^ of_flag) && !zf;
        default: cond = 1'b0;
      endcase
    end
  end

  // Flags only follow OPq from a healthy instruction; with the gate enabled a
  // faulting instruction further down the pipe also freezes them
`ifdef EXECUTE_CC_GATE_EN
  assign cc_we = (bus.E_icode == IOPQ) && (bus.E_stat == SAOK) &&
                 (bus.m_stat == SAOK) && (bus.W_stat == SAOK);
`else
  logic unused_stat;
  assign unused_stat = ^{bus.m_stat, bus.W_stat};
  assign cc_we = (bus.E_icode == IOPQ) && (bus.E_stat == SAOK);
`endif

  assign bus.e_valE = alu_out;
  assign bus.e_Cnd  = cond;
  // A not-taken cmove must not write its destination
  assign bus.e_dstE = (bus.E_icode == IRRMOVQ && !cond) ? RNONE : bus.E_dstE;

  // Condition-code register and M pipeline register; bubble still lets CC update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cc      <= 3'b100;
      bus.M_icode <= INOP;
      bus.M_Cnd   <= 1'b0;
      bus.M_valE  <= 64'd0;
      bus.M_valA  <= 64'd0;
      bus.M_dstE  <= RNONE;
      bus.M_dstM  <= RNONE;
      bus.M_stat  <= SAOK;
    end else begin
      if (cc_we) begin
        bus.cc <= {new_zf, new_sf, new_of};
      end
      if (bus.M_bubble) begin
        bus.M_icode <= INOP;
        bus.M_Cnd   <= 1'b0;
        bus.M_valE  <= 64'd0;
        bus.M_valA  <= 64'd0;
        bus.M_dstE  <= RNONE;
        bus.M_dstM  <= RNONE;
        bus.M_stat  <= SAOK;
      end else begin
        bus.M_icode <= bus.E_icode;
        bus.M_Cnd   <= cond;
        bus.M_valE  <= alu_out;
        bus.M_valA  <= bus.E_valA;
        bus.M_dstE  <= bus.e_dstE;
        bus.M_dstM  <= bus.E_dstM;
        bus.M_stat  <= bus.E_stat;
      end
    end
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  rising-edge clock for CC register and M pipeline register.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 E_icode, E_ifun  input  4 each  instruction code/function from E register.
REQ-004 E_valA, E_valB, E_valC  input  64 each  operand values from E register.
REQ-005 E_dstE, E_dstM  input  4 each  destination register IDs; 4'hF = RNONE.
REQ-006 E_stat  input  2  status, 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-007 M_bubble  input  1  load NOP bubble into M register this edge.
REQ-008 m_stat, W_stat  input  2 each  downstream status for CC gating (REQ-030).
REQ-009 e_valE  output  64  combinational ALU result, forwarded to decode.
REQ-010 e_dstE  output  4  combinational effective dstE, forwarded to decode.
REQ-011 e_Cnd  output  1  combinational condition result.
REQ-012 cc  output  3  registered {ZF,SF,OF}.
REQ-013 M_icode, M_dstE, M_dstM  output  4 each  registered.
REQ-014 M_valE, M_valA  output  64 each  registered.
REQ-015 M_Cnd  output  1; M_stat  output  2  registered.

Function
REQ-016 aluA SHALL be E_valA for IRRMOVQ(2)/IOPQ(6); E_valC for IIRMOVQ(3)/IRMMOVQ(4)/IMRMOVQ(5); -8 for ICALL(8)/IPUSHQ(10); +8 for IRET(9)/IPOPQ(11); 0 otherwise.
REQ-017 aluB SHALL be E_valB for codes 4,5,6,8,9,10,11; 0 for all others.
REQ-018 ALU function SHALL be E_ifun for IOPQ (0 add, 1 sub, 2 and, 3 xor), add otherwise; IOPQ with ifun>3 SHALL yield 0.
REQ-019 e_valE SHALL be aluB op aluA, 64-bit wrap-around; sub computes aluB-aluA.
REQ-020 New ZF = (e_valE==0); SF = e_valE[63]; OF for add = aluA[63]==aluB[63] && e_valE[63]!=aluA[63]; for sub = aluA[63]!=aluB[63] && e_valE[63]!=aluB[63]; and/xor OF=0.
REQ-021 cc SHALL update at rising edge only when E_icode==IOPQ (subject to REQ-030); otherwise hold.
REQ-022 e_Cnd from current cc and E_ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7-15 give 0.
REQ-023 e_Cnd SHALL be evaluated only for E_icode IRRMOVQ and IJXX(7); other codes drive 1.
REQ-024 e_dstE SHALL be RNONE when E_icode==IRRMOVQ and e_Cnd==0, else E_dstE.
REQ-025 M register SHALL load, one-cycle latency: M_icode<=E_icode, M_Cnd<=e_Cnd, M_valE<=e_valE, M_valA<=E_valA, M_dstE<=e_dstE, M_dstM<=E_dstM, M_stat<=E_stat.
REQ-026 M_bubble=1 SHALL load bubble: M_icode=1 (NOP), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF, M_stat=0; cc update of REQ-021 SHALL still apply.
REQ-027 E_stat!=AOK SHALL suppress cc update regardless of E_icode.

Reset
REQ-028 rst_n low SHALL immediately force cc={1,0,0} and all M outputs to bubble values of REQ-026, independent of clk.
REQ-029 First rising edge after rst_n deasserts SHALL perform a normal load; reset asserted mid-instruction discards it.

Configuration
REQ-030 Macro EXECUTE_CC_GATE_EN: defined -> cc update also suppressed when m_stat!=AOK or W_stat!=AOK; undefined -> m_stat/W_stat ignored, ports retained.

Verification
REQ-031 IOPQ sub, valA=5, valB=5 -> e_valE=0, next cc={1,0,0}.
REQ-032 IOPQ add, valA=valB=64'h4000_0000_0000_0000 -> e_valE=64'h8000_0000_0000_0000, cc={0,1,1}.
REQ-033 cc={0,1,0}, IRRMOVQ ifun=3 (cmove), E_dstE=2 -> e_Cnd=0, e_dstE=4'hF, M_dstE=4'hF next edge.
REQ-034 IPUSHQ valB=64'h100 with M_bubble=1 -> e_valE=64'hF8, M_icode=1, M_dstE=4'hF after edge.
REQ-035 With EXECUTE_CC_GATE_EN, IOPQ result 0 while m_stat=2 -> cc unchanged; without macro -> cc={1,0,0}.
REQ-036 rst_n pulsed low mid-cycle between edges -> cc={1,0,0}, M_icode=1, M_stat=0 immediately.
